// File: rtl/arith_core.sv
// Arithmetic execution core: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV, with a ready/busy handshake towards the register slave.
module arith_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [1:0]       instruction,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [1:0]         op;
    logic [CNT_W-1:0]   cnt;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    always_comb begin
        add_full = {1'b0, num1} + {1'b0, num2};
        sub_full = {1'b0, num1} - {1'b0, num2};
        acc_nxt  = mplier[0] ? (acc + mcand) : acc;
        // Remainder stays below the divisor, so a negative trial difference
        // always shows up as a set top bit of the WIDTH+1 wide result.
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, divisor};
        div_ge    = ~div_diff[WIDTH];
        rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= OP_ADD;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            result      <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op          <= instruction;
                        ready       <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        case (instruction)
                            OP_ADD: begin
                                result   <= add_full[WIDTH-1:0];
                                overflow <= add_full[WIDTH];
                                state    <= DONE;
                            end
                            OP_SUB: begin
                                result   <= sub_full[WIDTH-1:0];
                                overflow <= sub_full[WIDTH];
                                state    <= DONE;
                            end
                            OP_MUL: begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, num1};
                                mplier <= num2;
                                busy   <= 1'b1;
                                state  <= CALC;
                            end
                            default: begin
                                rem     <= '0;
                                quo     <= num1;
                                divisor <= num2;
                                busy    <= 1'b1;
                                state   <= CALC;
                            end
                        endcase
                    end
                end

                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op == OP_MUL) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (cnt == LAST_CNT) begin
                            result   <= acc_nxt[WIDTH-1:0];
                            overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
                            state    <= DONE;
                        end
                    end else if (divisor == '0) begin
                        result      <= '1;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        if (cnt == LAST_CNT) begin
                            result <= quo_nxt;
                            state  <= DONE;
                        end
                    end
                end

                DONE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
